// File: rtl/disp_pkg.sv
// Shared display constants, FSM state type and hex-to-segment table.
package disp_pkg;

  localparam int unsigned DIGITS    = 4;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [3:0]  ANODE_OFF = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  // Active-low abcdefg patterns, entry i is the glyph for nibble i.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // Index of the most significant nonzero nibble; 0 when the value is zero.
  function automatic logic [1:0] top_digit(input logic [15:0] v);
    logic [1:0] t;
    t = 2'd0;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'h0) t = 2'(i);
    end
    return t;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit hex nibble to active-low seven-segment decoder.
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Table lookup.
  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/display_source_scheduler.sv
// Round-robin sharing of one 4-digit seven-segment display between NUM_SRC
// producers, with dwell timer and multiplexed digit scan.
// Optional: DISP_LEADING_BLANK_EN blanks digits above the top nonzero nibble.
module display_source_scheduler
  import disp_pkg::*;
#(
  parameter  int unsigned NUM_SRC      = 4,
  parameter  int unsigned DWELL_CYCLES = 100000000,
  parameter  int unsigned REFRESH_BITS = 20,
  localparam int unsigned IDX_W        = $clog2(NUM_SRC)
) (
  input  logic                    clk_100mhz,
  input  logic                    reset,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [16*NUM_SRC-1:0]   src_value,
  output logic [NUM_SRC-1:0]      src_ready,
  output logic [IDX_W-1:0]        cur_src,
  output logic [3:0]              Anode_Activate,
  output logic [6:0]              LED_out
);

  localparam int unsigned DW_W = $clog2(DWELL_CYCLES);

  state_e                  state_q;
  logic [DW_W-1:0]         dwell_q;
  logic [IDX_W-1:0]        ptr_q;
  logic [IDX_W-1:0]        ptr_d;
  logic [IDX_W-1:0]        cur_src_q;
  logic [15:0]             value_q;
  logic [REFRESH_BITS-1:0] cnt_q;
  logic [3:0]              anode_q;
  logic [6:0]              led_q;

  logic [15:0]             vals [NUM_SRC];
  logic [IDX_W-1:0]        cand;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_found;
  logic                    accept_c;
  logic                    grant_c;
  logic [1:0]              digit;
  logic [3:0]              nibble;
  logic [6:0]              seg;
  logic                    lit;

  // Split the flat value bus into per-source words.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_vals
    assign vals[g] = src_value[16*g +: 16];
  end

  // Round-robin search starting at the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_SRC);
      if (!win_found && src_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign accept_c  = (state_q == ST_IDLE) || (dwell_q == '0);
  assign grant_c   = accept_c && win_found && !reset;
  assign src_ready = grant_c ? (NUM_SRC'(1) << win_idx) : '0;
  assign ptr_d     = (win_idx == IDX_W'(NUM_SRC - 1)) ? '0 : win_idx + IDX_W'(1);

  // Scheduler FSM: capture on grant, then count the dwell down and hold at 0.
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dwell_q   <= '0;
      ptr_q     <= '0;
      cur_src_q <= '0;
      value_q   <= '0;
    end else if (grant_c) begin
      state_q   <= ST_SHOW;
      dwell_q   <= DW_W'(DWELL_CYCLES - 1);
      ptr_q     <= ptr_d;
      cur_src_q <= win_idx;
      value_q   <= vals[win_idx];
    end else if (dwell_q != '0) begin
      dwell_q   <= dwell_q - DW_W'(1);
    end
  end

  // Free-running scan counter; its top two bits pick the digit.
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_q + REFRESH_BITS'(1);
  end

  assign digit = cnt_q[REFRESH_BITS-1 -: 2];

  // Select the nibble for the digit being scanned.
  always_comb begin
    case (digit)
      2'd0:    nibble = value_q[3:0];
      2'd1:    nibble = value_q[7:4];
      2'd2:    nibble = value_q[11:8];
      default: nibble = value_q[15:12];
    endcase
  end

`ifdef DISP_LEADING_BLANK_EN
  assign lit = (digit <= top_digit(value_q));
`else
  assign lit = 1'b1;
`endif

  hex_to_seg u_hex_to_seg (
    .hex_i (nibble),
    .seg_o (seg)
  );

  // Registered pin drivers; blank while idle or when the digit is suppressed.
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      anode_q <= ANODE_OFF;
      led_q   <= SEG_BLANK;
    end else if ((state_q == ST_SHOW) && lit) begin
      anode_q <= ~(4'b0001 << digit);
      led_q   <= seg;
    end else begin
      anode_q <= ANODE_OFF;
      led_q   <= SEG_BLANK;
    end
  end

  assign cur_src        = cur_src_q;
  assign Anode_Activate = anode_q;
  assign LED_out        = led_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed self-checking bench for display_source_scheduler.
module tb_display_source_scheduler;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned DWELL   = 8;
  localparam int unsigned RB      = 4;

  logic        clk_100mhz = 1'b0;
  logic        reset;
  logic [3:0]  src_valid;
  logic [63:0] src_value;
  logic [3:0]  src_ready;
  logic [1:0]  cur_src;
  logic [3:0]  Anode_Activate;
  logic [6:0]  LED_out;

  int n_cmp = 0;
  int n_bad = 0;

  display_source_scheduler #(
    .NUM_SRC      (NUM_SRC),
    .DWELL_CYCLES (DWELL),
    .REFRESH_BITS (RB)
  ) dut (
    .clk_100mhz     (clk_100mhz),
    .reset          (reset),
    .src_valid      (src_valid),
    .src_value      (src_value),
    .src_ready      (src_ready),
    .cur_src        (cur_src),
    .Anode_Activate (Anode_Activate),
    .LED_out        (LED_out)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    src_valid = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Watch 20 cycles of scan; every lit digit must show its own nibble.
  task automatic scan_check(input string tag, input logic [15:0] v);
    logic [3:0] seen;
    logic [3:0] mask;
    logic [3:0] nib;
    int         d;
    seen = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      if (Anode_Activate != 4'b1111) begin
        case (Anode_Activate)
          4'b1110: d = 0;
          4'b1101: d = 1;
          4'b1011: d = 2;
          4'b0111: d = 3;
          default: begin
            d = 0;
            check({tag, " anode"}, Anode_Activate, 4'b1110);
          end
        endcase
        nib = v[4*d +: 4];
        check({tag, " seg"}, LED_out, seg_of(nib));
        seen = seen | ~Anode_Activate;
      end else begin
        check({tag, " blank seg"}, LED_out, 7'b1111111);
      end
      tick();
    end
`ifdef DISP_LEADING_BLANK_EN
    if (v[15:12] != 4'h0)     mask = 4'b1111;
    else if (v[11:8] != 4'h0) mask = 4'b0111;
    else if (v[7:4] != 4'h0)  mask = 4'b0011;
    else                      mask = 4'b0001;
`else
    mask = 4'b1111;
`endif
    check({tag, " digits lit"}, seen, mask);
  endtask

  initial begin
    reset     = 1'b1;
    src_valid = 4'b0000;
    src_value = 64'h0;
    #1;
    check("rst anode", Anode_Activate, 4'b1111);
    check("rst seg", LED_out, 7'b1111111);
    check("rst cur", cur_src, 2'd0);
    check("rst ready", src_ready, 4'b0000);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // 1: idle, nothing requested
    for (int c = 0; c < 100; c++) begin
      check("t1 anode", Anode_Activate, 4'b1111);
      check("t1 seg", LED_out, 7'b1111111);
      check("t1 ready", src_ready, 4'b0000);
      tick();
    end

    // 2: single source, same-cycle ready, digit order
    src_value[15:0] = 16'h1234;
    src_valid       = 4'b0001;
    #1;
    check("t2 ready", src_ready, 4'b0001);
    tick();
    src_valid = 4'b0000;
    #1;
    check("t2 cur", cur_src, 2'd0);
    check("t2 ready drop", src_ready, 4'b0000);
    tick();
    tick();
    scan_check("t2", 16'h1234);

    // 3: all valid, grants rotate exactly DWELL apart
    do_reset();
    src_value = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    src_valid = 4'b1111;
    #1;
    for (int c = 0; c <= 32; c++) begin
      check($sformatf("t3 ready c%0d", c), src_ready,
            (c % 8 == 0) ? (32'd1 << ((c / 8) % 4)) : 32'd0);
      tick();
      if (c % 8 == 0) check($sformatf("t3 cur c%0d", c), cur_src, 32'((c / 8) % 4));
    end
    src_valid = 4'b0000;

    // 4: src 2 once, mid-dwell request ignored, then hold and late request
    do_reset();
    src_value[47:32] = 16'hBEEF;
    src_valid        = 4'b0100;
    #1;
    check("t4 ready", src_ready, 4'b0100);
    tick();
    src_valid = 4'b0000;
    check("t4 cur", cur_src, 2'd2);
    tick();
    tick();
    src_valid       = 4'b0001;
    src_value[15:0] = 16'h5555;
    #1;
    check("t4 mid-dwell ready", src_ready, 4'b0000);
    src_valid = 4'b0000;
    for (int c = 0; c < 10; c++) tick();
    scan_check("t4 hold", 16'hBEEF);
    check("t4 cur hold", cur_src, 2'd2);
    src_value[31:16] = 16'h1111;
    src_valid        = 4'b0010;
    #1;
    check("t4 late ready", src_ready, 4'b0010);
    tick();
    src_valid = 4'b0000;
    check("t4 late cur", cur_src, 2'd1);
    tick();
    tick();
    scan_check("t4 new", 16'h1111);

    // 5: reset mid-dwell clears everything including the RR pointer
    do_reset();
    src_value = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    src_valid = 4'b0010;
    #1;
    check("t5 ready", src_ready, 4'b0010);
    tick();
    src_valid = 4'b0000;
    tick();
    tick();
    tick();
    src_valid = 4'b1111;
    reset     = 1'b1;
    #1;
    check("t5 rst anode", Anode_Activate, 4'b1111);
    check("t5 rst seg", LED_out, 7'b1111111);
    check("t5 rst cur", cur_src, 2'd0);
    check("t5 rst ready", src_ready, 4'b0000);
    tick();
    reset = 1'b0;
    #1;
    check("t5 regrant ready", src_ready, 4'b0001);
    tick();
    src_valid = 4'b0000;
    check("t5 regrant cur", cur_src, 2'd0);

    // 6: small values, leading digits depend on the build option
    do_reset();
    src_value[15:0] = 16'h0007;
    src_valid       = 4'b0001;
    #1;
    check("t6 ready", src_ready, 4'b0001);
    tick();
    src_valid = 4'b0000;
    tick();
    tick();
    scan_check("t6 seven", 16'h0007);
    src_value[15:0] = 16'h0000;
    src_valid       = 4'b0001;
    #1;
    check("t6 zero ready", src_ready, 4'b0001);
    tick();
    src_valid = 4'b0000;
    tick();
    tick();
    scan_check("t6 zero", 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
Shares the board's single 4-digit seven-segment display between up to NUM_SRC producers, such as the core result, PC and debug registers. It is a round-robin scheduler with a valid/ready capture handshake and a per-source dwell timer. It also contains the multiplexed digit-scan engine that drives Anode_Activate/LED_out. It sits between the core and the board pins in the top-level display wrapper.

Parameters:
NUM_SRC, 4, number of requesters (2..8)
DWELL_CYCLES, 100000000, minimum clk_100mhz cycles a captured value stays displayed before re-arbitration (>=2)
REFRESH_BITS, 20, width of the free-running scan counter; the top 2 bits select the digit

Ports:
clk_100mhz  input  1  system clock
reset  input  1  asynchronous, active-high reset
src_valid  input  NUM_SRC  per-source request; the source holds it and its value until ready
src_value  input  16*NUM_SRC  source i value in bits [16*i+15:16*i]
src_ready  output  NUM_SRC  one-hot, combinational; transfer happens on the edge where valid&ready
cur_src  output  $clog2(NUM_SRC)  index of the source currently displayed (registered)
Anode_Activate  output  4  active-low digit enables
LED_out  output  7  active-low segments; bit6=a … bit0=g

Behaviour:
- Reset (asynchronous): FSM=IDLE, Anode_Activate=4'b1111, LED_out=7'b1111111, cur_src=0, src_ready=0, dwell and scan counters=0, RR pointer favours source 0.
- FSM states: IDLE and SHOW.
  - IDLE: display blanked (anodes all 1). When any src_valid is set, grant and go to SHOW.
  - SHOW: the dwell counter loads DWELL_CYCLES-1 on grant and decrements to 0, then holds at 0.
- Accept window: the cycle where state==IDLE, or state==SHOW with dwell==0.
  - In the accept window, src_ready = one-hot of the RR winner among asserted src_valid; otherwise src_ready=0.
  - On the accept edge: latch the winner's value, set cur_src=winner, set pointer=winner+1 mod NUM_SRC, reload dwell.
  - Switching is seamless; there is no blank gap between values.
- Dwell expired with no valid: keep showing the last value and stay accept-ready. A later request is accepted in the first cycle it is asserted.
- Single persistent requester: it is re-granted every DWELL_CYCLES cycles, and its value is refreshed at each grant.
- Round-robin: search starts at the pointer and wraps. A source whose valid drops before grant loses its slot and receives no ready.
- src_valid changes mid-dwell are ignored until the accept window.
- Scan: the REFRESH_BITS counter runs free from reset in all states.
  - digit = cnt[REFRESH_BITS-1:REFRESH_BITS-2].
  - Digit d shows nibble value[4d+3:4d] with Anode_Activate = ~(1<<d), so digit 0 (LSB) → 4'b1110.
  - Anode_Activate and LED_out are registered, 1-cycle latency from the counter/value.
  - A new value appears on the next scanned digit after the capture edge.
- Hex encoding (abcdefg, active-low): 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111, 8 0000000, 9 0000100, A 0001000, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000.
- Reset asserted mid-dwell or mid-handshake: everything clears immediately, and a pending transfer is not counted as complete.

Optional Feature:
Macro DISP_LEADING_BLANK_EN.
- Defined: any digit above the most significant nonzero nibble is blanked (its anode stays 1). Digit 0 is always lit, so a value of 0 shows a single "0".
- Undefined: all four digits are always lit in SHOW.

Decomposition:
- Shared package disp_pkg: DIGITS=4, SEG_BLANK=7'b1111111, ANODE_OFF=4'b1111, FSM state typedef, hex→segment constant table.
- One sub-module, hex_to_seg: combinational 4-bit → 7-bit decoder driven from the package table.

Test Plan:
Bench parameters: NUM_SRC=4, DWELL_CYCLES=8, REFRESH_BITS=4.
1. Reset, no valid → Anode_Activate=1111 and LED_out=1111111 for 100 cycles; src_ready=0.
2. src_valid=0001, value0=16'h1234 → src_ready=0001 in that same cycle; cur_src=0. Across one scan period, anodes 1110/1101/1011/0111 show 4/3/2/1 = 1001100/0000110/0010010/1001111.
3. All valid, values 16'hA000+i → grants 0,1,2,3,0 exactly 8 cycles apart; each src_ready is a one-cycle pulse.
4. Only src 2 valid (16'hBEEF), then dropped after grant → display holds BEEF indefinitely. A new src 1 request at cycle 20 after dwell end is granted in the first cycle it is asserted.
5. Reset pulsed at cycle 3 of dwell → outputs blank immediately; the next request grants source 0 first.
6. DISP_LEADING_BLANK_EN defined, value 16'h0007 → only anode 1110 lit, showing 0001111; value 16'h0000 → digit 0 shows 0000001.
